// File: rtl/add_icb_driver.sv
// ---------------------------------------------------------------------------
// add_icb_driver
//
// ICB master sequencer placed directly in front of the memory-mapped adder
// peripheral. It takes one operand pair from a valid/ready request port and
// runs a fixed transaction sequence on the ICB bus:
//   write AUGEND <- a, write ADDEND <- b, write CONTROL <- 1,
//   wait WAIT_CYC settle cycles, read SUM.
// The SUM read data, or an error indication, is returned on a valid/ready
// result port. The driver never adds anything itself.
//
// Ports
//   clk            in   1   single clock, rising edge
//   rst_n          in   1   asynchronous active-low reset
//   req_valid      in   1   operand pair valid
//   req_ready      out  1   driver idle, request can be accepted
//   req_a          in   32  augend
//   req_b          in   32  addend
//   res_valid      out  1   result valid (held until res_ready)
//   res_ready      in   1   client accepts result
//   res_sum        out  32  SUM read from the peripheral (0 on error)
//   res_err        out  1   an ICB response of this sequence carried err
//   icb_cmd_valid  out  1   ICB command valid
//   icb_cmd_ready  in   1   ICB command ready
//   icb_cmd_read   out  1   1 = read, 0 = write
//   icb_cmd_addr   out  32  command address
//   icb_cmd_wdata  out  32  write data
//   icb_cmd_wmask  out  4   byte mask
//   icb_rsp_valid  in   1   ICB response valid
//   icb_rsp_ready  out  1   ICB response ready (only while awaiting one)
//   icb_rsp_rdata  in   32  read data
//   icb_rsp_err    in   1   response error
// ---------------------------------------------------------------------------
module add_icb_driver #(
    parameter logic [31:0] BASE_ADDR = 32'h1004_2000,
    parameter logic [31:0] AUG_OFS   = 32'h0000_0000,
    parameter logic [31:0] ADD_OFS   = 32'h0000_0004,
    parameter logic [31:0] CTRL_OFS  = 32'h0000_0008,
    parameter logic [31:0] SUM_OFS   = 32'h0000_000C,
    parameter int unsigned WAIT_CYC  = 2
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,

    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_sum,
    output logic        res_err,

    output logic        icb_cmd_valid,
    input  logic        icb_cmd_ready,
    output logic        icb_cmd_read,
    output logic [31:0] icb_cmd_addr,
    output logic [31:0] icb_cmd_wdata,
    output logic [3:0]  icb_cmd_wmask,

    input  logic        icb_rsp_valid,
    output logic        icb_rsp_ready,
    input  logic [31:0] icb_rsp_rdata,
    input  logic        icb_rsp_err
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CMD  = 3'd1,
        S_RSP  = 3'd2,
        S_WAIT = 3'd3,
        S_DONE = 3'd4
    } state_t;

    // Transaction index within the fixed sequence.
    localparam logic [1:0] STEP_AUG  = 2'd0;
    localparam logic [1:0] STEP_ADD  = 2'd1;
    localparam logic [1:0] STEP_CTRL = 2'd2;
    localparam logic [1:0] STEP_SUM  = 2'd3;

    typedef struct packed {
        logic        read;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } icb_cmd_t;

    // WAIT lasts WAIT_CYC cycles: the counter is loaded with WAIT_CYC-1 and
    // the exit happens in the cycle where it reads zero.
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYC == 0) ? 4'd0 : 4'(WAIT_CYC - 1);

    // Command fields for one step of the sequence. Addresses wrap modulo 2^32.
    function automatic icb_cmd_t build_cmd(input logic [1:0]  step,
                                           input logic [31:0] op_a,
                                           input logic [31:0] op_b);
        icb_cmd_t c;
        c.read  = 1'b0;
        c.wmask = 4'hF;
        c.addr  = BASE_ADDR + AUG_OFS;
        c.wdata = op_a;
        case (step)
            STEP_AUG: begin
                c.addr  = BASE_ADDR + AUG_OFS;
                c.wdata = op_a;
            end
            STEP_ADD: begin
                c.addr  = BASE_ADDR + ADD_OFS;
                c.wdata = op_b;
            end
            STEP_CTRL: begin
                c.addr  = BASE_ADDR + CTRL_OFS;
                c.wdata = 32'h0000_0001;
            end
            default: begin
                c.read  = 1'b1;
                c.addr  = BASE_ADDR + SUM_OFS;
                c.wdata = 32'h0000_0000;
                c.wmask = 4'h0;
            end
        endcase
        return c;
    endfunction

    state_t      state_q, state_d;
    logic [1:0]  step_q, step_d;
    logic [3:0]  wait_q, wait_d;
    logic [31:0] sum_q, sum_d;
    logic        err_q, err_d;
    icb_cmd_t    cmd_q;
    logic [31:0] a_q, b_q;

    logic        op_load;
    logic        cmd_load;
    logic [31:0] op_a, op_b;

    // Operands are captured on the request handshake; the AUGEND command is
    // built in that same cycle, so it takes the operands straight from the
    // request port rather than from the (not yet loaded) operand registers.
    assign op_a = op_load ? req_a : a_q;
    assign op_b = op_load ? req_b : b_q;

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        wait_d  = wait_q;
        sum_d   = sum_q;
        err_d   = err_q;
        op_load = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    op_load = 1'b1;
                    step_d  = STEP_AUG;
                    err_d   = 1'b0;
                    state_d = S_CMD;
                end
            end

            S_CMD: begin
                if (icb_cmd_ready) begin
                    state_d = S_RSP;
                end
            end

            S_RSP: begin
                if (icb_rsp_valid) begin
                    if (icb_rsp_err) begin
                        // Any error abandons the rest of the sequence.
                        err_d   = 1'b1;
                        sum_d   = 32'h0000_0000;
                        state_d = S_DONE;
                    end else begin
                        case (step_q)
                            STEP_AUG, STEP_ADD: begin
                                step_d  = step_q + 2'd1;
                                state_d = S_CMD;
                            end
                            STEP_CTRL: begin
                                step_d = STEP_SUM;
                                if (WAIT_CYC == 0) begin
                                    state_d = S_CMD;
                                end else begin
                                    wait_d  = WAIT_LOAD;
                                    state_d = S_WAIT;
                                end
                            end
                            default: begin
                                sum_d   = icb_rsp_rdata;
                                state_d = S_DONE;
                            end
                        endcase
                    end
                end
            end

            S_WAIT: begin
                if (wait_q == 4'd0) begin
                    state_d = S_CMD;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end

            S_DONE: begin
                if (res_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Command fields are loaded once on entry to CMD and then held, so they
    // stay stable for the whole time icb_cmd_valid waits on icb_cmd_ready.
    assign cmd_load = (state_d == S_CMD) && (state_q != S_CMD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            step_q  <= STEP_AUG;
            wait_q  <= 4'd0;
            sum_q   <= 32'h0000_0000;
            err_q   <= 1'b0;
            cmd_q   <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            wait_q  <= wait_d;
            sum_q   <= sum_d;
            err_q   <= err_d;
            if (cmd_load) begin
                cmd_q <= build_cmd(step_d, op_a, op_b);
            end
        end
    end

    // Operand holding registers carry no control meaning and need no reset.
    always_ff @(posedge clk) begin
        if (op_load) begin
            a_q <= req_a;
            b_q <= req_b;
        end
    end

    assign req_ready     = (state_q == S_IDLE);
    assign res_valid     = (state_q == S_DONE);
    assign res_sum       = sum_q;
    assign res_err       = err_q;

    assign icb_cmd_valid = (state_q == S_CMD);
    assign icb_cmd_read  = cmd_q.read;
    assign icb_cmd_addr  = cmd_q.addr;
    assign icb_cmd_wdata = cmd_q.wdata;
    assign icb_cmd_wmask = cmd_q.wmask;

    // Responses are back-pressured in every state except RSP.
    assign icb_rsp_ready = (state_q == S_RSP);

endmodule

// File: doc/add_icb_driver.md
# add_icb_driver

ICB master sequencer that sits directly upstream of the memory-mapped adder peripheral. It accepts an operand pair on a valid/ready request port and performs a fixed ICB transaction sequence: write AUGEND, write ADDEND, write CONTROL=1, wait a fixed settle time, read SUM. It returns the sum, or an error flag, on a valid/ready result port. This lets a hardware client use the adder without CPU involvement.

## Interface
- BASE_ADDR, 32'h1004_2000, base address of the adder peripheral
- AUG_OFS, 32'h0, AUGEND register offset
- ADD_OFS, 32'h4, ADDEND register offset
- CTRL_OFS, 32'h8, CONTROL register offset
- SUM_OFS, 32'hC, SUM register offset
- WAIT_CYC, 2, settle cycles between CONTROL write response and SUM read command (0..15)

Ports:
- clk  in  1  single clock, all logic rising-edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  operand pair valid
- req_ready  out  1  driver idle, can accept a request
- req_a  in  32  augend
- req_b  in  32  addend
- res_valid  out  1  result valid
- res_ready  in  1  client accepts result
- res_sum  out  32  SUM read from the peripheral
- res_err  out  1  an ICB response carried err
- icb_cmd_valid  out  1  ICB command valid
- icb_cmd_ready  in  1  ICB command ready
- icb_cmd_read  out  1  1=read, 0=write
- icb_cmd_addr  out  32  command address
- icb_cmd_wdata  out  32  write data
- icb_cmd_wmask  out  4  byte mask
- icb_rsp_valid  in  1  ICB response valid
- icb_rsp_ready  out  1  ICB response ready
- icb_rsp_rdata  in  32  read data
- icb_rsp_err  in  1  response error

## Operation
- States: IDLE, CMD, RSP, WAIT, DONE. A 2-bit step counter selects the transaction: 0=write AUGEND, 1=write ADDEND, 2=write CONTROL, 3=read SUM.
- IDLE: req_ready=1. On req_valid, latch req_a/req_b, set step=0, clear res_err, go to CMD.
- CMD: icb_cmd_valid=1. Fields by step:
  - step 0: addr=BASE_ADDR+AUG_OFS, wdata=a, wmask=4'hF, read=0
  - step 1: addr=BASE_ADDR+ADD_OFS, wdata=b, wmask=4'hF, read=0
  - step 2: addr=BASE_ADDR+CTRL_OFS, wdata=32'h1, wmask=4'hF, read=0
  - step 3: addr=BASE_ADDR+SUM_OFS, wdata=0, wmask=4'h0, read=1
- In CMD, all icb_cmd_* fields are registered and held stable until icb_cmd_valid&icb_cmd_ready. On that handshake, go to RSP and drop icb_cmd_valid. Only one transaction is outstanding at a time.
- RSP: icb_rsp_ready=1, and it is 0 in every other state. Responses arriving outside RSP are back-pressured, not dropped. On icb_rsp_valid:
  - icb_rsp_err=1: set res_err=1, res_sum=0, go to DONE (abort the remaining steps).
  - step 0 or 1: step++, go to CMD.
  - step 2: step=3, go to WAIT (or straight to CMD if WAIT_CYC=0).
  - step 3: res_sum=icb_rsp_rdata, go to DONE.
- WAIT: a 4-bit down-counter loaded with WAIT_CYC-1 counts to 0, then the block goes to CMD.
- DONE: res_valid=1, with res_sum and res_err stable. On res_ready, go to IDLE. req_ready=0 until IDLE.
- Arithmetic: address = BASE_ADDR + offset, 32-bit, modulo 2^32. The driver does no summation itself.

## Timing
- Reset values: icb_cmd_valid=0, icb_cmd_read=0, icb_cmd_addr=0, icb_cmd_wdata=0, icb_cmd_wmask=0, icb_rsp_ready=0, res_valid=0, res_sum=0, res_err=0, state=IDLE. req_ready is decoded from state, so it is 1 after reset.
- Reset asserted mid-sequence: the block returns to IDLE immediately. An in-flight ICB command is abandoned, and the peripheral's partial register writes are not undone.
- Latency with an always-ready slave responding 1 cycle after command acceptance (request handshake at cycle 0):
  - AUGEND command accepted at cycle 1
  - rsp at cycles 2, 4, 6
  - WAIT occupies cycles 7..6+WAIT_CYC
  - SUM command at 7+WAIT_CYC, rsp at 8+WAIT_CYC
  - res_valid at 9+WAIT_CYC (11 with default)
- Each icb_cmd_ready stall cycle, or rsp delay cycle, adds exactly one cycle.
- res_valid holds until res_ready. A new req is accepted no earlier than the cycle after the result handshake.

## Test plan
- Zero-wait slave model, a=32'h0000_0005, b=32'h0000_0007, SUM returns 32'hC. Required: write sequence to 0x10042000/04/08 with data 5/7/1, read of 0x1004200C, res_valid at cycle 11, res_sum=32'hC, res_err=0.
- icb_cmd_ready held low 3 cycles on the ADDEND write. Required: addr/wdata/wmask stay stable throughout, and res_valid is delayed by exactly 3 cycles.
- icb_rsp_err=1 on the CONTROL write response. Required: no SUM read is issued, res_valid=1, res_err=1, res_sum=0.
- res_ready held low 5 cycles with req_valid high. Required: res_valid and res_sum stay stable, req_ready=0, and the second request is accepted only after the result handshake.
- WAIT_CYC=0 variant, a=32'hFFFF_FFFF, b=1, slave returns 0. Required: the SUM command follows the CONTROL response with no wait, res_valid at cycle 9, res_sum=0.
- rst_n pulsed low during the RSP of the ADDEND write. Required: all outputs return to their reset values asynchronously, req_ready=1, and the next request restarts at step 0.
